// File: rtl/ram_arbiter_if.sv
// Requester handshakes and RAM control bus for ram_arbiter.
// The arbiter uses the slave view; requesters and the RAM use the master view.
interface ram_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [7:0]        wdata0;
  logic              ack0;
  logic [7:0]        rdata0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [7:0]        wdata1;
  logic              ack1;
  logic [7:0]        rdata1;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_enable;
  logic              ram_write;
  logic              ram_read;
  logic              busy;

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    input  ack0, rdata0, ack1, rdata1,
    input  ram_addr, ram_enable, ram_write, ram_read, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    output ack0, rdata0, ack1, rdata1,
    output ram_addr, ram_enable, ram_write, ram_read, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter and access sequencer for a single-port
// synchronous block RAM with a shared tri-state data bus.
module ram_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  ram_arbiter_if.slave bus,
  inout  wire  [7:0]   ram_data
);

  typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_DATA} state_t;

  state_t            state;
  logic              owner;
  logic              last_grant;
  logic [7:0]        wdata_l;

  logic              elig0;
  logic              elig1;
  logic              gnt;
  logic              gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [7:0]        gnt_wdata;

  // A port is masked during its own ack cycle so a held request is not replayed.
  always_comb begin
    elig0 = bus.req0 & ~bus.ack0;
    elig1 = bus.req1 & ~bus.ack1;
    if (elig0 && elig1) gnt = ~last_grant;
    else                gnt = elig1;
    gnt_we    = gnt ? bus.we1    : bus.we0;
    gnt_addr  = gnt ? bus.addr1  : bus.addr0;
    gnt_wdata = gnt ? bus.wdata1 : bus.wdata0;
  end

  assign ram_data = (state == WR) ? wdata_l : 8'bz;
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      wdata_l        <= '0;
      bus.ram_addr   <= '0;
      bus.ram_enable <= 1'b0;
      bus.ram_write  <= 1'b0;
      bus.ram_read   <= 1'b0;
      bus.ack0       <= 1'b0;
      bus.ack1       <= 1'b0;
      bus.rdata0     <= '0;
      bus.rdata1     <= '0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            owner          <= gnt;
            last_grant     <= gnt;
            wdata_l        <= gnt_wdata;
            bus.ram_addr   <= gnt_addr;
            bus.ram_enable <= 1'b1;
            bus.ram_write  <= gnt_we;
            state          <= gnt_we ? WR : RD_ADDR;
          end
        end
        WR: begin
          bus.ram_enable <= 1'b0;
          bus.ram_write  <= 1'b0;
          bus.ack0       <= ~owner;
          bus.ack1       <= owner;
          state          <= IDLE;
        end
        RD_ADDR: begin
          // RAM registers its output on this edge; open its bus driver next.
          bus.ram_enable <= 1'b0;
          bus.ram_read   <= 1'b1;
          state          <= RD_DATA;
        end
        RD_DATA: begin
          bus.ram_read <= 1'b0;
          if (owner) bus.rdata1 <= ram_data;
          else       bus.rdata0 <= ram_data;
          bus.ack0     <= ~owner;
          bus.ack1     <= owner;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized checks of ram_arbiter against a behavioural
// synchronous RAM model and a per-address scoreboard.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  wire  [7:0] ram_data;
  int         total = 0;
  int         bad = 0;
  logic       mon_on = 1'b0;

  ram_arbiter_if #(.ADDR_W(12)) bus ();

  ram_arbiter #(.ADDR_W(12)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .ram_data (ram_data)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: synchronous store, registered read output.
  logic [7:0] mem [0:4095];
  logic [7:0] ram_q = 8'h00;
  initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (bus.ram_enable) begin
      if (bus.ram_write) mem[bus.ram_addr] <= ram_data;
      else               ram_q <= mem[bus.ram_addr];
    end
  end
  assign ram_data = bus.ram_read ? ram_q : 8'bz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && reset_n) begin
      chk("bus_contention", 32'(bus.ram_read & bus.ram_write), 32'd0);
      chk("dual_ack", 32'(bus.ack0 & bus.ack1), 32'd0);
      if (bus.ram_read) chk("rd_data_x", 32'($isunknown(ram_data)), 32'd0);
    end
  end

  typedef struct {
    logic        r0, w0;
    logic [11:0] a0;
    logic [7:0]  d0;
    logic        r1, w1;
    logic [11:0] a1;
    logic [7:0]  d1;
    logic [1:0]  ack;   // {ack0, ack1}
    logic [7:0]  rd0, rd1;
    logic [2:0]  ewr;   // {ram_enable, ram_write, ram_read}
    logic        busy;
    logic [11:0] raddr;
  } vec_t;

  function automatic vec_t mk(logic r0, logic w0, logic [11:0] a0, logic [7:0] d0,
                              logic r1, logic w1, logic [11:0] a1, logic [7:0] d1,
                              logic [1:0] ack, logic [7:0] rd0, logic [7:0] rd1,
                              logic [2:0] ewr, logic busy, logic [11:0] raddr);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.ack = ack; v.rd0 = rd0; v.rd1 = rd1; v.ewr = ewr; v.busy = busy; v.raddr = raddr;
    return v;
  endfunction

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [11:0] a, input logic [7:0] d);
    if (p == 0) begin bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
    else        begin bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
  endtask

  function automatic logic get_ack(input int p);
    return (p == 0) ? bus.ack0 : bus.ack1;
  endfunction

  function automatic logic [7:0] get_rdata(input int p);
    return (p == 0) ? bus.rdata0 : bus.rdata1;
  endfunction

  // Issue one transaction and check request-to-ack latency and read data.
  task automatic xfer(input int p, input logic w, input logic [11:0] a,
                      input logic [7:0] d, input int lat, input logic [7:0] exp_rd);
    int n = 0;
    @(negedge clk);
    set_port(p, 1'b1, w, a, d);
    do begin
      @(posedge clk); #1;
      n++;
    end while (!get_ack(p) && n < 10);
    set_port(p, 1'b0, 1'b0, 12'h000, 8'h00);
    chk($sformatf("xfer_p%0d_latency", p), 32'(n), 32'(lat));
    if (!w) chk($sformatf("xfer_p%0d_rdata", p), 32'(get_rdata(p)), 32'(exp_rd));
  endtask

  vec_t        t [27];
  int          order [$];
  logic        prev0, prev1;
  logic        act [2];
  logic        rw [2];
  logic [3:0]  ra [2];
  logic [7:0]  rd [2];
  int          age [2];
  logic [7:0]  last_rd [2];
  logic [7:0]  model [16];

  initial begin
    set_port(0, 1'b0, 1'b0, 12'h000, 8'h00);
    set_port(1, 1'b0, 1'b0, 12'h000, 8'h00);

    // Simultaneous writes from reset (port 0 first), then write/read/isolation.
    t[0]  = mk(1,1,12'h001,8'h11, 1,1,12'h002,8'h22, 2'b00,8'h00,8'h00,3'b110,1,12'h001);
    t[1]  = mk(1,1,12'h001,8'h11, 1,1,12'h002,8'h22, 2'b10,8'h00,8'h00,3'b000,0,12'h001);
    t[2]  = mk(1,1,12'h001,8'h11, 1,1,12'h002,8'h22, 2'b00,8'h00,8'h00,3'b110,1,12'h002);
    t[3]  = mk(0,0,12'h000,8'h00, 1,1,12'h002,8'h22, 2'b01,8'h00,8'h00,3'b000,0,12'h002);
    t[4]  = mk(0,0,12'h000,8'h00, 1,1,12'h002,8'h22, 2'b00,8'h00,8'h00,3'b000,0,12'h002);
    t[5]  = mk(1,1,12'h010,8'h3A, 0,0,12'h000,8'h00, 2'b00,8'h00,8'h00,3'b110,1,12'h010);
    t[6]  = mk(1,1,12'h010,8'h3A, 0,0,12'h000,8'h00, 2'b10,8'h00,8'h00,3'b000,0,12'h010);
    t[7]  = mk(1,1,12'h010,8'h3A, 0,0,12'h000,8'h00, 2'b00,8'h00,8'h00,3'b000,0,12'h010);
    t[8]  = mk(1,0,12'h001,8'h00, 0,0,12'h000,8'h00, 2'b00,8'h00,8'h00,3'b100,1,12'h001);
    t[9]  = mk(1,0,12'h001,8'h00, 0,0,12'h000,8'h00, 2'b00,8'h00,8'h00,3'b001,1,12'h001);
    t[10] = mk(1,0,12'h001,8'h00, 0,0,12'h000,8'h00, 2'b10,8'h11,8'h00,3'b000,0,12'h001);
    t[11] = mk(1,0,12'h001,8'h00, 0,0,12'h000,8'h00, 2'b00,8'h11,8'h00,3'b000,0,12'h001);
    t[12] = mk(0,0,12'h000,8'h00, 1,0,12'h002,8'h00, 2'b00,8'h11,8'h00,3'b100,1,12'h002);
    t[13] = mk(0,0,12'h000,8'h00, 1,0,12'h002,8'h00, 2'b00,8'h11,8'h00,3'b001,1,12'h002);
    t[14] = mk(0,0,12'h000,8'h00, 1,0,12'h002,8'h00, 2'b01,8'h11,8'h22,3'b000,0,12'h002);
    t[15] = mk(0,0,12'h000,8'h00, 1,0,12'h002,8'h00, 2'b00,8'h11,8'h22,3'b000,0,12'h002);
    t[16] = mk(1,0,12'h010,8'h00, 0,0,12'h000,8'h00, 2'b00,8'h11,8'h22,3'b100,1,12'h010);
    t[17] = mk(1,0,12'h010,8'h00, 0,0,12'h000,8'h00, 2'b00,8'h11,8'h22,3'b001,1,12'h010);
    t[18] = mk(1,0,12'h010,8'h00, 0,0,12'h000,8'h00, 2'b10,8'h3A,8'h22,3'b000,0,12'h010);
    t[19] = mk(1,0,12'h010,8'h00, 0,0,12'h000,8'h00, 2'b00,8'h3A,8'h22,3'b000,0,12'h010);
    t[20] = mk(0,0,12'h000,8'h00, 1,1,12'h030,8'h77, 2'b00,8'h3A,8'h22,3'b110,1,12'h030);
    t[21] = mk(0,0,12'h000,8'h00, 1,1,12'h030,8'h77, 2'b01,8'h3A,8'h22,3'b000,0,12'h030);
    t[22] = mk(0,0,12'h000,8'h00, 1,1,12'h030,8'h77, 2'b00,8'h3A,8'h22,3'b000,0,12'h030);
    t[23] = mk(0,0,12'h000,8'h00, 1,0,12'h030,8'h00, 2'b00,8'h3A,8'h22,3'b100,1,12'h030);
    t[24] = mk(0,0,12'h000,8'h00, 1,0,12'h030,8'h00, 2'b00,8'h3A,8'h22,3'b001,1,12'h030);
    t[25] = mk(0,0,12'h000,8'h00, 1,0,12'h030,8'h00, 2'b01,8'h3A,8'h77,3'b000,0,12'h030);
    t[26] = mk(0,0,12'h000,8'h00, 1,0,12'h030,8'h00, 2'b00,8'h3A,8'h77,3'b000,0,12'h030);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(bus.ack0), 0);
    chk("rst_ack1", 32'(bus.ack1), 0);
    chk("rst_rdata0", 32'(bus.rdata0), 0);
    chk("rst_rdata1", 32'(bus.rdata1), 0);
    chk("rst_ewr", 32'({bus.ram_enable, bus.ram_write, bus.ram_read}), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_raddr", 32'(bus.ram_addr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_on  = 1'b1;

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      set_port(0, t[i].r0, t[i].w0, t[i].a0, t[i].d0);
      set_port(1, t[i].r1, t[i].w1, t[i].a1, t[i].d1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ack0", i), 32'(bus.ack0), 32'(t[i].ack[1]));
      chk($sformatf("v%0d_ack1", i), 32'(bus.ack1), 32'(t[i].ack[0]));
      chk($sformatf("v%0d_rdata0", i), 32'(bus.rdata0), 32'(t[i].rd0));
      chk($sformatf("v%0d_rdata1", i), 32'(bus.rdata1), 32'(t[i].rd1));
      chk($sformatf("v%0d_ewr", i), 32'({bus.ram_enable, bus.ram_write, bus.ram_read}), 32'(t[i].ewr));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(t[i].busy));
      chk($sformatf("v%0d_raddr", i), 32'(bus.ram_addr), 32'(t[i].raddr));
    end

    // Fairness: both ports request continuously; last grant was port 1.
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 12'h100, 8'hA0);
    set_port(1, 1'b1, 1'b1, 12'h101, 8'hB1);
    prev0 = 1'b0;
    prev1 = 1'b0;
    for (int c = 0; c < 40 && order.size() < 6; c++) begin
      @(posedge clk); #1;
      if (bus.ack0) begin chk("fair_pulse0", 32'(prev0), 0); order.push_back(0); end
      if (bus.ack1) begin chk("fair_pulse1", 32'(prev1), 0); order.push_back(1); end
      prev0 = bus.ack0;
      prev1 = bus.ack1;
    end
    set_port(0, 1'b0, 1'b0, 12'h000, 8'h00);
    set_port(1, 1'b0, 1'b0, 12'h000, 8'h00);
    chk("fair_count", 32'(order.size()), 6);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("fair_order%0d", i), 32'(order[i]), 32'(i % 2));
    repeat (3) @(posedge clk);
    #1;
    chk("fair_idle_busy", 32'(bus.busy), 0);

    // Reset asserted while the read sits in RD_ADDR.
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 12'h010, 8'h00);
    @(posedge clk); #1;
    chk("mid_rdaddr_ewr", 32'({bus.ram_enable, bus.ram_write, bus.ram_read}), 32'b100);
    #2;
    reset_n = 1'b0;
    #1;
    set_port(0, 1'b0, 1'b0, 12'h000, 8'h00);
    chk("mid_rst_ewr", 32'({bus.ram_enable, bus.ram_write, bus.ram_read}), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_raddr", 32'(bus.ram_addr), 0);
    chk("mid_rst_rdata0", 32'(bus.rdata0), 0);
    chk("mid_rst_rdata1", 32'(bus.rdata1), 0);
    @(posedge clk); #1;
    chk("mid_rst_noack", 32'({bus.ack0, bus.ack1}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_noack_after", 32'({bus.ack0, bus.ack1}), 0);
    xfer(0, 1'b0, 12'h010, 8'h00, 3, 8'h3A);
    xfer(1, 1'b1, 12'h040, 8'h5C, 2, 8'h00);

    // Random mixed traffic against a scoreboard over addresses 0x200..0x20F.
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    last_rd[0] = 8'h3A;
    last_rd[1] = 8'h00;
    for (int p = 0; p < 2; p++) begin act[p] = 1'b0; age[p] = 0; end
    for (int cyc = 0; cyc < 1100; cyc++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (act[p] && get_ack(p)) begin
          if (!rw[p]) begin
            chk($sformatf("rnd_p%0d_rdata", p), 32'(get_rdata(p)), 32'(model[ra[p]]));
            last_rd[p] = model[ra[p]];
          end else begin
            model[ra[p]] = rd[p];
          end
          chk($sformatf("rnd_p%0d_other_rdata", p), 32'(get_rdata(1 - p)), 32'(last_rd[1 - p]));
          act[p] = 1'b0;
          set_port(p, 1'b0, 1'b0, 12'h000, 8'h00);
        end else if (act[p]) begin
          age[p]++;
          if (age[p] > 12) begin
            chk($sformatf("rnd_p%0d_timeout", p), 32'(age[p]), 12);
            act[p] = 1'b0;
            set_port(p, 1'b0, 1'b0, 12'h000, 8'h00);
          end
        end else if (cyc < 1000 && $urandom_range(0, 2) == 0) begin
          act[p] = 1'b1;
          age[p] = 0;
          rw[p]  = 1'($urandom_range(0, 1));
          ra[p]  = 4'($urandom_range(0, 15));
          rd[p]  = 8'($urandom_range(0, 255));
          set_port(p, 1'b1, rw[p], {8'h20, ra[p]}, rd[p]);
        end
      end
    end
    chk("rnd_drained", 32'({act[0], act[1]}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port block RAM.
- The RAM has a synchronous 8-bit store, a tri-state data bus, and enable/write/read strobes.
- Shares the RAM between requester 0 (CPU) and requester 1 (DMA/video), using round-robin on simultaneous requests.
- Generates the RAM enable/write/read timing, drives write data onto the shared bus, and captures read data into per-port registers.

Parameters:
- ADDR_W, 12, RAM address width (matches RAM address bus).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 transaction request (level).
- we0  input  1  port 0: 1 = write, 0 = read; sampled with req0.
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  8  port 0 write data.
- ack0  output  1  port 0 one-cycle completion pulse.
- rdata0  output  8  port 0 read data, valid from ack0.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- ram_addr  output  ADDR_W  RAM address bus.
- ram_enable  output  1  RAM enable.
- ram_write  output  1  RAM write strobe.
- ram_read  output  1  RAM output-enable (RAM drives bus while high).
- ram_data  inout  8  shared RAM data bus.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low.
- Outputs:
  - All RAM-side outputs, ack*, rdata* and busy are registered or decoded from the state register only; no combinational path from req* to the RAM.
  - ram_data is driven with the latched wdata only in WR; otherwise it is high-Z.
- Reset values: state=IDLE, ram_enable=0, ram_write=0, ram_read=0, ram_addr=0, ram_data=Z, ack0=ack1=0, rdata0=rdata1=0, busy=0, last_grant=1 (so port 0 wins the first tie).
- FSM states: IDLE, WR, RD_ADDR, RD_DATA.
- IDLE:
  - Eligible port = reqN high and ackN low in the same cycle. A port's request is masked during its own ack cycle.
  - If no port is eligible, stay in IDLE.
  - If one port is eligible, grant it.
  - If both are eligible, grant the port != last_grant.
  - On grant: latch owner, we, addr and wdata; set last_grant=owner; go to WR if we=1, else RD_ADDR.
- WR (1 cycle):
  - ram_enable=1, ram_write=1, ram_read=0, ram_addr=latched addr, ram_data=latched wdata.
  - Next state IDLE; ack[owner]=1 in the following cycle.
- RD_ADDR (1 cycle):
  - ram_enable=1, ram_write=0, ram_read=0, ram_addr=latched addr.
  - The RAM registers its output at the end of this cycle.
  - Next state RD_DATA.
- RD_DATA (1 cycle):
  - ram_enable=0, ram_read=1, ram_data=Z (driven by RAM).
  - rdata[owner] <= ram_data at the end of the cycle.
  - Next state IDLE; ack[owner]=1 in the following cycle.
- Latency, request cycle to ack cycle:
  - Write: 2 cycles.
  - Read: 3 cycles; rdata valid in the ack cycle and held until that port's next read completes.
- ack: exactly one-cycle pulse, never asserted on both ports in the same cycle. The non-owner's rdata is never modified.
- Requester rule: hold reqN, weN, addrN and wdataN stable until ackN. A port that keeps reqN high after ackN is treated as a new transaction and is eligible from the cycle after ackN.
- Back-to-back:
  - The ack cycle is an IDLE cycle, so the other port may be granted in that cycle.
  - Minimum gap between transactions is one IDLE cycle.
- Bus safety: ram_read and ram_data drive are never high in the same cycle.
- Reset mid-transaction: immediate return to reset values.
  - The aborted transaction is not acked; its write may or may not be committed.
  - rdata is not updated.
- Inputs of a non-granted port are ignored; there is no queueing beyond the request level.

Test Plan:
- Write then read, port 0: write 0x3A to addr 0x010, then read addr 0x010.
  - Write: ram_enable=ram_write=1 in cycle 1, ack0 in cycle 2.
  - Read: ack0 3 cycles after request with rdata0=0x3A.
- Simultaneous requests after reset: port 0 write 0x11 @0x001, port 1 write 0x22 @0x002.
  - Port 0 is granted first, then port 1.
  - Readback gives 0x11 and 0x22.
- Fairness: both ports hold req continuously for 6 transactions.
  - Grants alternate 0,1,0,1,0,1; each ack is a one-cycle pulse with no duplicate ack.
- Read isolation: port 1 reads 0x002 (0x22) while rdata0 holds 0x3A.
  - rdata1=0x22 and rdata0 stays 0x3A; port 0's rdata is unaffected.
- Bus contention check: random mixed read/write traffic for 1000 cycles.
  - Assert ram_read and ram_data-drive are never both active.
  - ram_data is never X during RD_DATA after the first write.
- Reset mid-read: pull reset_n low during RD_ADDR.
  - All outputs return to reset values immediately, with no ack.
  - After release, a fresh read completes normally.
